intergral_frame_sched: RTL

//  Frame scheduler for the intergral (power/integration) stage of the 16384-pt RFFT decode path.

---
 rtl/intergral_frame_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/intergral_frame_sched.sv
// Frame scheduler for the intergral stage of the 16384-pt RFFT decode path.
// Reads one frame (2**ADDR_WIDTH words x LANES complex samples) from a dual-port sample RAM,
// feeding col1 with words 0, 1, then the even words, and col2 with the odd words from 3 upward.
// It then waits for the intergral ready window to close and reports frame completion.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     frame request, accepted only in IDLE (and not in the done cycle)
//   busy / done               not-IDLE flag / 1-cycle end-of-frame pulse
//   err_timeout               sticky drain timeout flag, cleared by an accepted start
//   ram_rd_en, ram_addr_a/b   RAM read request (1-cycle read latency)
//   ram_rdata_a/b             RAM read data, lane k = {real, imag} at bits [k*2W +: 2W]
//   valid, col1_*/col2_*      beat to intergral; data forced to 0 outside the active beats
//   index_col_1/2             word index of the current col1/col2 beat
//   ready                     intergral result window
module intergral_frame_sched #(
  parameter int unsigned IN_DATA_WIDTH = 32,
  parameter int unsigned LANES         = 4,
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           err_timeout,
  output logic                           ram_rd_en,
  output logic [ADDR_WIDTH-1:0]          ram_addr_a,
  output logic [ADDR_WIDTH-1:0]          ram_addr_b,
  input  logic [LANES*2*IN_DATA_WIDTH-1:0] ram_rdata_a,
  input  logic [LANES*2*IN_DATA_WIDTH-1:0] ram_rdata_b,
  output logic                           valid,
  output logic [LANES*IN_DATA_WIDTH-1:0] col1_r,
  output logic [LANES*IN_DATA_WIDTH-1:0] col1_i,
  output logic [LANES*IN_DATA_WIDTH-1:0] col2_r,
  output logic [LANES*IN_DATA_WIDTH-1:0] col2_i,
  output logic [ADDR_WIDTH-1:0]          index_col_1,
  output logic [ADDR_WIDTH-1:0]          index_col_2,
  input  logic                           ready
);

  localparam int unsigned W    = IN_DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] One       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] Two       = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] Idx2Idle  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] HalfWords = ADDR_WIDTH'(2 ** (ADDR_WIDTH - 1));
  localparam logic [ADDR_WIDTH-1:0] LastBeat  = ADDR_WIDTH'(2 ** (ADDR_WIDTH - 1) + 1);
  localparam logic [ADDR_WIDTH-1:0] LastEven  = ADDR_WIDTH'(2 ** ADDR_WIDTH - 2);
  localparam logic [CntW-1:0]       TmoLast   = CntW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StPrime, StStream, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] beat_q, beat_d;
  logic [CntW-1:0]       tmo_q, tmo_d;
  logic                  act_a_q, act_a_d;
  logic                  act_b_q, act_b_d;
  logic [ADDR_WIDTH-1:0] idx1_q, idx1_d;
  logic [ADDR_WIDTH-1:0] idx2_q, idx2_d;
  logic                  ready_q;
  logic                  seen_q, seen_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  issue, b_on;
  logic [ADDR_WIDTH-1:0] nxt, nxt_m1, addr_a, addr_b;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    seen_d  = seen_q;
    done_d  = 1'b0;
    err_d   = err_q;
    issue   = 1'b0;
    nxt     = '0;

    unique case (state_q)
      StIdle: begin
        seen_d = 1'b0;
        // A start coinciding with the done pulse is dropped, not deferred.
        if (start && !done_q) begin
          state_d = StPrime;
          err_d   = 1'b0;
        end
      end
      StPrime: begin
        issue   = 1'b1;
        beat_d  = '0;
        state_d = StStream;
      end
      StStream: begin
        if (beat_q == LastBeat) begin
          state_d = StDrain;
          tmo_d   = '0;
        end else begin
          // Addresses lead data by one cycle: fetch for the next beat.
          issue  = 1'b1;
          nxt    = beat_q + One;
          beat_d = beat_q + One;
        end
      end
      StDrain: begin
        if (ready_q && !ready && seen_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StStream || state_q == StDrain) && ready && !ready_q) seen_d = 1'b1;

    // col1: 0, 1, then 2(n-1); the final beat repeats the last even word rather than wrapping.
    nxt_m1 = nxt - One;
    if (nxt < Two)             addr_a = nxt;
    else if (nxt <= HalfWords) addr_a = {nxt_m1[ADDR_WIDTH-2:0], 1'b0};
    else                       addr_a = LastEven;
    // col2: 2n-1 for beats 2 .. HalfWords.
    addr_b = {nxt_m1[ADDR_WIDTH-2:0], 1'b1};
    b_on   = issue && (nxt >= Two) && (nxt <= HalfWords);

    act_a_d = issue;
    act_b_d = b_on;
    idx1_d  = issue ? addr_a : '0;
    idx2_d  = b_on ? addr_b : Idx2Idle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      tmo_q   <= '0;
      act_a_q <= 1'b0;
      act_b_q <= 1'b0;
      idx1_q  <= '0;
      idx2_q  <= Idx2Idle;
      ready_q <= 1'b0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      act_a_q <= act_a_d;
      act_b_q <= act_b_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      ready_q <= ready;
      seen_q  <= seen_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign valid       = act_a_q;
  assign index_col_1 = idx1_q;
  assign index_col_2 = idx2_q;
  assign ram_rd_en   = issue;
  assign ram_addr_a  = issue ? addr_a : '0;
  assign ram_addr_b  = b_on ? addr_b : '0;

  // Gating uses the registered beat flags so stale RAM output never leaks onto the columns.
  always_comb begin
    col1_r = '0;
    col1_i = '0;
    col2_r = '0;
    col2_i = '0;
    for (int k = 0; k < LANES; k++) begin
      if (act_a_q) begin
        col1_r[k*W +: W] = ram_rdata_a[k*2*W + W +: W];
        col1_i[k*W +: W] = ram_rdata_a[k*2*W +: W];
      end
      if (act_b_q) begin
        col2_r[k*W +: W] = ram_rdata_b[k*2*W + W +: W];
        col2_i[k*W +: W] = ram_rdata_b[k*2*W +: W];
      end
    end
  end

endmodule
